datapath_param: RTL and testbench
=================================

Name: datapath_param

Overview:
- Parametrised successor to the K&S processor datapath: configurable data width, address width and register-file depth.
- Adds a wider ALU opcode, registered condition flags with an explicit update enable, and a PC that wraps at the address width.
- Sits between the control FSM and the RAM.
- Control drives enables and selects; the datapath returns the decoded opcode and registered flags.

Parameters:
- DATA_W, 16, word width of RAM data, IR, register file and ALU; minimum 12.
- ADDR_W, 5, RAM address width; PC width; minimum 2, ADDR_W ≤ DATA_W-4.
- NREG, 4, number of general registers; power of two, 2..16; REG_W = clog2(NREG).
- OPC_W, 5, opcode field width taken from IR MSBs; OPC_W + 3*REG_W ≤ DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  1  with pc_enable, load PC from IR address field.
- pc_enable  in  1  PC update enable.
- ir_enable  in  1  IR <= data_in.
- addr_sel  in  1  0: addr_ram = PC; 1: addr_ram = IR address field.
- c_sel  in  1  register write source; 0: ALU result; 1: data_in.
- write_reg_enable  in  1  write selected source into rf[dst].
- flags_enable  in  1  latch ALU flags.
- operation  in  3  ALU op.
- decoded_instruction  out  OPC_W  IR[DATA_W-1 -: OPC_W].
- zero  out  1  registered flag.
- neg  out  1  registered flag.
- unsigned_overflow  out  1  registered flag.
- signed_overflow  out  1  registered flag.
- data_in  in  DATA_W  RAM read data.
- data_out  out  DATA_W  RAM write data.
- addr_ram  out  ADDR_W  RAM address.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously clears PC, IR, every rf entry and all four flags to 0.
  - Consequently addr_ram = 0, data_out = 0 and decoded_instruction = 0 during reset.
- IR fields:
  - dst = IR[3*REG_W-1:2*REG_W]
  - a = IR[2*REG_W-1:REG_W]
  - b = IR[REG_W-1:0]
  - addr field = IR[ADDR_W-1:0]; it overlaps the register fields by design.
- IR: loads data_in on a clk edge when ir_enable = 1; otherwise holds.
- PC, when pc_enable = 1:
  - branch = 1: PC <= addr field.
  - branch = 0: PC <= PC+1 mod 2^ADDR_W; all-ones wraps to 0.
  - pc_enable = 0: PC holds and branch is ignored.
- Address mux (combinational): addr_ram = addr_sel ? addr field : PC.
- Register file:
  - NREG x DATA_W, two combinational read ports (a, b).
  - One synchronous write port: write_reg_enable writes (c_sel ? data_in : alu_result) to rf[dst].
  - Writing and reading the same register in one cycle: read returns the old value; the new value is visible next cycle.
- data_out: combinational rf[dst] (store source).
- ALU (combinational, on A = rf[a], B = rf[b]):
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100–111: see Optional Feature.
- Flags, computed on the DATA_W-bit result:
  - zero = (result == 0).
  - neg = result[MSB].
  - unsigned_overflow: carry-out for ADD; borrow (A < B unsigned) for SUB; 0 for all other ops.
  - signed_overflow:
    - ADD: A and B have the same sign and result sign differs.
    - SUB: A and B have different signs and result sign ≠ A sign.
    - All other ops: 0.
  - All four flags latch together on a clk edge when flags_enable = 1 and hold otherwise.
  - Flags are independent of c_sel and write_reg_enable: a load with flags_enable = 1 still latches the ALU flags of the current A/B.
- Simultaneous events:
  - ir_enable and pc_enable in the same cycle: branch uses the OLD IR addr field.
  - ir_enable and write_reg_enable in the same cycle: dst comes from the old IR.
- Reset mid-operation: immediate clear; no partial write completes.

Optional Feature:
- Macro: DATAPATH_EXT_ALU_EN.
- Defined, the upper opcodes are:
  - 100 XOR: A^B.
  - 101 SHL: A<<1; unsigned_overflow = A[MSB].
  - 110 SHR: logical A>>1; unsigned_overflow = A[0].
  - 111 PASS: B.
  - signed_overflow = 0 for all four.
- Undefined: ops 100–111 give result 0.
  - zero = 1, other flags 0.
  - The register write still occurs if enabled.

Test Plan:
- Reset, then hold rst_n low for 3 cycles with all enables high: PC=0, IR=0, addr_ram=0, all flags 0, rf[0..3]=0.
- Load constants:
  - Stimulus: IR = opcode/dst=1 with c_sel=1, write_reg_enable=1, data_in=16'h7FFF; then dst=2, data_in=16'h0001.
  - Then IR with dst=3, a=1, b=2, op=000, c_sel=0, write_reg_enable=1, flags_enable=1.
  - Required: rf[3]=16'h8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- SUB borrow: rf[1]=16'h0003, rf[2]=16'h0005, op=001, flags_enable=1 -> result 16'hFFFE, unsigned_overflow=1, neg=1, signed_overflow=0; then flags_enable=0 with op=000 -> flags unchanged.
- PC wrap and branch:
  - PC=5'h1F with pc_enable=1, branch=0 -> PC=0.
  - IR addr field=5'h0A, branch=1, pc_enable=1 -> PC=5'h0A.
  - addr_sel=1 -> addr_ram=5'h0A; addr_sel=0 -> PC.
- Same-cycle hazard: ir_enable=1 with new IR and pc_enable=branch=1 -> PC takes old IR addr field.
- Ext ALU: with DATAPATH_EXT_ALU_EN, A=16'h8001, op=101 -> 16'h0002, unsigned_overflow=1; without the macro, same op -> result 0, zero=1.

Source files
------------

// File: rtl/datapath_param.sv
// datapath_param: parametrised processor datapath with PC, IR, register file, ALU and registered flags.
// Define DATAPATH_EXT_ALU_EN to enable XOR/SHL/SHR/PASS on ALU ops 100-111; otherwise those ops return 0.
module datapath_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NREG   = 4,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch,
  input  logic              pc_enable,
  input  logic              ir_enable,
  input  logic              addr_sel,
  input  logic              c_sel,
  input  logic              write_reg_enable,
  input  logic              flags_enable,
  input  logic [2:0]        operation,
  output logic [OPC_W-1:0]  decoded_instruction,
  output logic              zero,
  output logic              neg,
  output logic              unsigned_overflow,
  output logic              signed_overflow,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_ram
);

  localparam int REG_W = $clog2(NREG);
  localparam int LOW_W = (ADDR_W > 3*REG_W) ? ADDR_W : 3*REG_W;
  localparam int MSB   = DATA_W - 1;

  // Only the opcode and the low operand/address bits of IR are ever observed, so only those are stored.
  logic [OPC_W-1:0]  ir_opc;
  logic [LOW_W-1:0]  ir_low;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] rf [NREG];

  logic [REG_W-1:0]  dst;
  logic [REG_W-1:0]  sel_a;
  logic [REG_W-1:0]  sel_b;
  logic [ADDR_W-1:0] addr_field;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W:0]   sum_ext;
  logic              alu_uov;
  logic              alu_sov;

  assign dst        = ir_low[3*REG_W-1:2*REG_W];
  assign sel_a      = ir_low[2*REG_W-1:REG_W];
  assign sel_b      = ir_low[REG_W-1:0];
  assign addr_field = ir_low[ADDR_W-1:0];

  assign decoded_instruction = ir_opc;
  assign addr_ram            = addr_sel ? addr_field : pc;
  assign op_a                = rf[sel_a];
  assign op_b                = rf[sel_b];
  assign data_out            = rf[dst];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_opc <= '0;
      ir_low <= '0;
    end else if (ir_enable) begin
      ir_opc <= data_in[DATA_W-1 -: OPC_W];
      ir_low <= data_in[LOW_W-1:0];
    end
  end

  // Branch target comes from the IR value before this edge, even if IR is loading at the same time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (pc_enable) begin
      if (branch) pc <= addr_field;
      else        pc <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (write_reg_enable) begin
      rf[dst] <= c_sel ? data_in : alu_result;
    end
  end

  always_comb begin
    alu_result = '0;
    alu_uov    = 1'b0;
    alu_sov    = 1'b0;
    sum_ext    = '0;
    case (operation)
      3'b000: begin
        sum_ext    = {1'b0, op_a} + {1'b0, op_b};
        alu_result = sum_ext[DATA_W-1:0];
        alu_uov    = sum_ext[DATA_W];
        alu_sov    = (op_a[MSB] == op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
      end
      3'b001: begin
        alu_result = op_a - op_b;
        alu_uov    = (op_a < op_b);
        alu_sov    = (op_a[MSB] != op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
      end
      3'b010: alu_result = op_a & op_b;
      3'b011: alu_result = op_a | op_b;
`ifdef DATAPATH_EXT_ALU_EN
      3'b100: alu_result = op_a ^ op_b;
      3'b101: begin
        alu_result = {op_a[DATA_W-2:0], 1'b0};
        alu_uov    = op_a[MSB];
      end
      3'b110: begin
        alu_result = {1'b0, op_a[DATA_W-1:1]};
        alu_uov    = op_a[0];
      end
      3'b111: alu_result = op_b;
`endif
      default: alu_result = '0;
    endcase
  end

  // Flags track the ALU regardless of what gets written back, so a load can still latch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero              <= 1'b0;
      neg               <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_enable) begin
      zero              <= (alu_result == '0);
      neg               <= alu_result[MSB];
      unsigned_overflow <= alu_uov;
      signed_overflow   <= alu_sov;
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// tb_datapath_param: scoreboard-driven bench for datapath_param at DATA_W=16, ADDR_W=5, NREG=4, OPC_W=5.
// Follows DATAPATH_EXT_ALU_EN to pick the expected behaviour of ALU ops 100-111.
module tb_datapath_param;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NREG   = 4;
  localparam int OPC_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              branch = 1'b0;
  logic              pc_enable = 1'b0;
  logic              ir_enable = 1'b0;
  logic              addr_sel = 1'b0;
  logic              c_sel = 1'b0;
  logic              write_reg_enable = 1'b0;
  logic              flags_enable = 1'b0;
  logic [2:0]        operation = 3'd0;
  logic [OPC_W-1:0]  decoded_instruction;
  logic              zero;
  logic              neg;
  logic              unsigned_overflow;
  logic              signed_overflow;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_ram;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] e;
  logic [19:0] m;

  datapath_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .OPC_W(OPC_W)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .write_reg_enable(write_reg_enable),
    .flags_enable(flags_enable), .operation(operation), .decoded_instruction(decoded_instruction),
    .zero(zero), .neg(neg), .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .data_in(data_in), .data_out(data_out), .addr_ram(addr_ram)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk_ir(input logic [4:0] opc, input logic [1:0] d,
                                        input logic [1:0] a, input logic [1:0] b);
    return {opc, 5'b00000, d, a, b};
  endfunction

  // Reference ALU: returns {zero, neg, uov, sov, result}.
  function automatic logic [19:0] alu_model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    logic [16:0] w;
    logic        u;
    logic        s;
    r = 16'h0; u = 1'b0; s = 1'b0; w = 17'h0;
    case (op)
      3'd0: begin
        w = {1'b0, x} + {1'b0, y};
        r = w[15:0];
        u = w[16];
        s = (x[15] & y[15] & ~r[15]) | (~x[15] & ~y[15] & r[15]);
      end
      3'd1: begin
        r = x - y;
        u = (x < y);
        s = (x[15] ^ y[15]) & (r[15] ^ x[15]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
`ifdef DATAPATH_EXT_ALU_EN
      3'd4: r = x ^ y;
      3'd5: begin r = {x[14:0], 1'b0}; u = x[15]; end
      3'd6: begin r = {1'b0, x[15:1]}; u = x[0]; end
      3'd7: r = y;
`endif
      default: r = 16'h0;
    endcase
    return {(r == 16'h0), r[15], u, s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; addr_sel = 1'b0;
    c_sel = 1'b0; write_reg_enable = 1'b0; flags_enable = 1'b0; operation = 3'd0;
  endtask

  task automatic load_ir(input logic [15:0] w);
    data_in = w;
    ir_enable = 1'b1;
    tick();
    ir_enable = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] d, input logic [15:0] v);
    load_ir(mk_ir(5'd0, d, 2'd0, 2'd0));
    data_in = v;
    c_sel = 1'b1;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    c_sel = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    branch = 1'b1; pc_enable = 1'b1; ir_enable = 1'b1; addr_sel = 1'b1;
    c_sel = 1'b1; write_reg_enable = 1'b1; flags_enable = 1'b1; data_in = 16'hFFFF;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    repeat (3) tick();
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL reset_addr_field got %h exp %h", addr_ram, e); end
    addr_sel = 1'b0; #1;
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL reset_pc got %h exp %h", addr_ram, e); end
    checks++; e = exp_q.pop_front();
    if ({11'b0, decoded_instruction} !== e) begin errors++; $display("[TB] FAIL reset_ir got %h exp %h", decoded_instruction, e); end
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL reset_data_out got %h exp %h", data_out, e); end
    checks++; e = exp_q.pop_front();
    if ({12'b0, zero, neg, unsigned_overflow, signed_overflow} !== e) begin
      errors++; $display("[TB] FAIL reset_flags got %b%b%b%b exp %h", zero, neg, unsigned_overflow, signed_overflow, e);
    end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NREG; k++) begin
      load_ir(mk_ir(5'd0, k[1:0], 2'd0, 2'd0));
      exp_q.push_back(16'h0);
      checks++; e = exp_q.pop_front();
      if (data_out !== e) begin errors++; $display("[TB] FAIL reset_rf%0d got %h exp %h", k, data_out, e); end
    end
  endtask

  task automatic test_add_overflow();
    write_reg(2'd1, 16'h7FFF);
    write_reg(2'd2, 16'h0001);
    m = alu_model(3'd0, 16'h7FFF, 16'h0001);
    exp_q.push_back(m[15:0]);
    exp_q.push_back({12'b0, m[19:16]});
    exp_q.push_back(16'h0003);
    load_ir(mk_ir(5'h03, 2'd3, 2'd1, 2'd2));
    operation = 3'd0; write_reg_enable = 1'b1; flags_enable = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL add_result got %h exp %h", data_out, e); end
    checks++; e = exp_q.pop_front();
    if ({12'b0, zero, neg, unsigned_overflow, signed_overflow} !== e) begin
      errors++; $display("[TB] FAIL add_flags got %b%b%b%b exp %h", zero, neg, unsigned_overflow, signed_overflow, e);
    end
    checks++; e = exp_q.pop_front();
    if ({11'b0, decoded_instruction} !== e) begin errors++; $display("[TB] FAIL add_opcode got %h exp %h", decoded_instruction, e); end
  endtask

  task automatic test_sub_flags();
    write_reg(2'd1, 16'h0003);
    write_reg(2'd2, 16'h0005);
    m = alu_model(3'd1, 16'h0003, 16'h0005);
    exp_q.push_back(m[15:0]);
    exp_q.push_back({12'b0, m[19:16]});
    exp_q.push_back({12'b0, m[19:16]});
    load_ir(mk_ir(5'd0, 2'd0, 2'd1, 2'd2));
    operation = 3'd1; write_reg_enable = 1'b1; flags_enable = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL sub_result got %h exp %h", data_out, e); end
    checks++; e = exp_q.pop_front();
    if ({12'b0, zero, neg, unsigned_overflow, signed_overflow} !== e) begin
      errors++; $display("[TB] FAIL sub_flags got %b%b%b%b exp %h", zero, neg, unsigned_overflow, signed_overflow, e);
    end
    operation = 3'd0;
    tick();
    checks++; e = exp_q.pop_front();
    if ({12'b0, zero, neg, unsigned_overflow, signed_overflow} !== e) begin
      errors++; $display("[TB] FAIL flags_hold got %b%b%b%b exp %h", zero, neg, unsigned_overflow, signed_overflow, e);
    end
    // A load with flags_enable still latches the flags of the current A/B (3-3 = 0).
    load_ir(mk_ir(5'd0, 2'd3, 2'd1, 2'd1));
    m = alu_model(3'd1, 16'h0003, 16'h0003);
    exp_q.push_back(16'h1234);
    exp_q.push_back({12'b0, m[19:16]});
    operation = 3'd1; data_in = 16'h1234; c_sel = 1'b1; write_reg_enable = 1'b1; flags_enable = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL load_value got %h exp %h", data_out, e); end
    checks++; e = exp_q.pop_front();
    if ({12'b0, zero, neg, unsigned_overflow, signed_overflow} !== e) begin
      errors++; $display("[TB] FAIL load_flags got %b%b%b%b exp %h", zero, neg, unsigned_overflow, signed_overflow, e);
    end
  endtask

  task automatic test_pc();
    load_ir(16'h001F);
    exp_q.push_back(16'h001F); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    pc_enable = 1'b1; branch = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL pc_branch_1f got %h exp %h", addr_ram, e); end
    pc_enable = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL pc_wrap got %h exp %h", addr_ram, e); end
    branch = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL pc_hold got %h exp %h", addr_ram, e); end
    load_ir(16'h000A);
    exp_q.push_back(16'h000A); exp_q.push_back(16'h000A); exp_q.push_back(16'h000B);
    pc_enable = 1'b1; branch = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL pc_branch_0a got %h exp %h", addr_ram, e); end
    pc_enable = 1'b1;
    tick();
    idle();
    addr_sel = 1'b1; #1;
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL addr_sel_ir got %h exp %h", addr_ram, e); end
    addr_sel = 1'b0; #1;
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL addr_sel_pc got %h exp %h", addr_ram, e); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    exp_q.push_back(16'h000A); exp_q.push_back(16'h0015);
    data_in = 16'h0015; ir_enable = 1'b1; pc_enable = 1'b1; branch = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL hazard_pc got %h exp %h", addr_ram, e); end
    addr_sel = 1'b1; #1;
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL hazard_ir got %h exp %h", addr_ram, e); end
    addr_sel = 1'b0;
    // Loading a new IR while writing: the write lands in the old dst (1), rf[2] stays 5.
    load_ir(mk_ir(5'd0, 2'd1, 2'd0, 2'd0));
    w = mk_ir(5'h09, 2'd2, 2'd0, 2'd0);
    exp_q.push_back(16'h0009); exp_q.push_back(16'h0005); exp_q.push_back(w);
    data_in = w; ir_enable = 1'b1; c_sel = 1'b1; write_reg_enable = 1'b1;
    tick();
    idle();
    checks++; e = exp_q.pop_front();
    if ({11'b0, decoded_instruction} !== e) begin errors++; $display("[TB] FAIL hazard_opcode got %h exp %h", decoded_instruction, e); end
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL hazard_new_dst got %h exp %h", data_out, e); end
    load_ir(mk_ir(5'd0, 2'd1, 2'd0, 2'd0));
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL hazard_old_dst got %h exp %h", data_out, e); end
  endtask

  task automatic test_ext_alu();
    write_reg(2'd1, 16'h8001);
    for (int op = 2; op < 8; op++) begin
      m = alu_model(3'(op), 16'h8001, 16'h0005);
      exp_q.push_back(m[15:0]);
      exp_q.push_back({12'b0, m[19:16]});
      load_ir(mk_ir(5'd0, 2'd3, 2'd1, 2'd2));
      operation = 3'(op); write_reg_enable = 1'b1; flags_enable = 1'b1;
      tick();
      idle();
      checks++; e = exp_q.pop_front();
      if (data_out !== e) begin errors++; $display("[TB] FAIL alu_op%0d_result got %h exp %h", op, data_out, e); end
      checks++; e = exp_q.pop_front();
      if ({12'b0, zero, neg, unsigned_overflow, signed_overflow} !== e) begin
        errors++; $display("[TB] FAIL alu_op%0d_flags got %b%b%b%b exp %h", op, zero, neg, unsigned_overflow, signed_overflow, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    write_reg(2'd1, 16'hABCD);
    load_ir(16'h0007);
    data_in = 16'hFFFF; c_sel = 1'b1; write_reg_enable = 1'b1; pc_enable = 1'b1; ir_enable = 1'b1;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++; e = exp_q.pop_front();
    if ({11'b0, decoded_instruction} !== e) begin errors++; $display("[TB] FAIL midreset_ir got %h exp %h", decoded_instruction, e); end
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL midreset_data_out got %h exp %h", data_out, e); end
    tick();
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; e = exp_q.pop_front();
    if ({11'b0, addr_ram} !== e) begin errors++; $display("[TB] FAIL midreset_pc got %h exp %h", addr_ram, e); end
    exp_q.push_back(16'h0);
    load_ir(mk_ir(5'd0, 2'd1, 2'd0, 2'd0));
    checks++; e = exp_q.pop_front();
    if (data_out !== e) begin errors++; $display("[TB] FAIL midreset_rf1 got %h exp %h", data_out, e); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_flags();
    test_pc();
    test_back_to_back();
    test_ext_alu();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got running exp finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
